// File: rtl/storage_arbiter.sv
// Round-robin arbiter between instruction fetch and data ports in front of storage_controller.
// One access in flight at a time; each access is bounded by a timeout and answered with a one-cycle rvalid.
module storage_arbiter #(
    parameter logic [31:0] EXT_BASE       = 32'h0000_1000,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          MEM_W          = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req_i,
    input  logic [31:0]        if_addr_i,
    output logic               if_gnt_o,
    output logic               if_rvalid_o,
    output logic [MEM_W-1:0]   if_rdata_o,
    output logic               if_err_o,
    input  logic               d_req_i,
    input  logic               d_we_i,
    input  logic [MEM_W/8-1:0] d_be_i,
    input  logic [31:0]        d_addr_i,
    input  logic [MEM_W-1:0]   d_wdata_i,
    output logic               d_gnt_o,
    output logic               d_rvalid_o,
    output logic [MEM_W-1:0]   d_rdata_o,
    output logic               d_err_o,
    input  logic               programming_mode_i,
    output logic               mem_access_o,
    output logic               mem_is_writing_o,
    output logic [31:0]        mem_addr_o,
    output logic [MEM_W-1:0]   mem_d_in_o,
    output logic [MEM_W/8-1:0] mem_be_o,
    output logic               mem_ext_o,
    input  logic [MEM_W-1:0]   mem_d_out_i,
    input  logic               mem_out_valid_i
);

    localparam int BE_W  = MEM_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Owner encoding doubles as the per-port index: 0 = fetch, 1 = data.
    state_t             r_state;
    logic               r_owner;
    logic               r_last_owner;
    logic [31:0]        r_addr;
    logic               r_we;
    logic [BE_W-1:0]    r_be;
    logic [MEM_W-1:0]   r_wdata;
    logic               r_ext;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;

    logic               w_can_grant;
    logic               w_d_win;
    logic               w_if_win;
    logic [31:0]        w_gnt_addr;
    logic               w_issue;
    logic               w_done;
    logic               w_rvalid [2];
    logic [MEM_W-1:0]   w_rdata  [2];

    // On a tie the port that did not own the previous access wins.
    assign w_can_grant = (r_state == ST_IDLE) && !programming_mode_i && !rst;
    assign w_d_win     = w_can_grant && d_req_i && (!if_req_i || (r_last_owner == 1'b0));
    assign w_if_win    = w_can_grant && if_req_i && !w_d_win;
    assign w_gnt_addr  = w_d_win ? d_addr_i : if_addr_i;

    assign w_issue = (r_state == ST_ISSUE);
    assign w_done  = w_issue && (mem_out_valid_i || (r_cnt == CNT_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_ext        <= 1'b0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_if_win || w_d_win) begin
                        r_state <= ST_ISSUE;
                        r_owner <= w_d_win;
                        r_addr  <= w_gnt_addr;
                        r_we    <= w_d_win && d_we_i;
                        r_be    <= w_d_win ? d_be_i : {BE_W{1'b1}};
                        r_wdata <= w_d_win ? d_wdata_i : '0;
                        r_ext   <= (w_gnt_addr >= EXT_BASE);
                        r_cnt   <= '0;
                    end
                end
                ST_ISSUE: begin
                    // A valid arriving on the limit cycle takes priority over the timeout.
                    if (mem_out_valid_i) begin
                        r_err   <= 1'b0;
                        r_state <= ST_RESP;
                    end else if (r_cnt == CNT_LIMIT) begin
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_last_owner <= r_owner;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Each port keeps its own read-data register so it holds between responses.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [MEM_W-1:0] r_rdata;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rdata <= '0;
            end else if (w_done && (r_owner == 1'(gi))) begin
                r_rdata <= mem_out_valid_i ? mem_d_out_i : '0;
            end
        end

        assign w_rdata[gi]  = r_rdata;
        assign w_rvalid[gi] = (r_state == ST_RESP) && (r_owner == 1'(gi));
    end

    assign if_gnt_o    = w_if_win;
    assign if_rvalid_o = w_rvalid[0];
    assign if_rdata_o  = w_rdata[0];
    assign if_err_o    = w_rvalid[0] && r_err;

    assign d_gnt_o     = w_d_win;
    assign d_rvalid_o  = w_rvalid[1];
    assign d_rdata_o   = w_rdata[1];
    assign d_err_o     = w_rvalid[1] && r_err;

    assign mem_access_o     = w_issue;
    assign mem_is_writing_o = w_issue && r_we;
    assign mem_addr_o       = w_issue ? r_addr  : '0;
    assign mem_d_in_o       = w_issue ? r_wdata : '0;
    assign mem_be_o         = w_issue ? r_be    : '0;
    assign mem_ext_o        = w_issue && r_ext;

endmodule

// File: tb/tb_storage_arbiter.sv
// Self-checking bench for storage_arbiter: arbitration table, directed corner cases,
// and randomized transactions against a round-robin reference model.
module tb_storage_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        pmode = 1'b0;
    logic        mem_access, mem_is_writing, mem_ext;
    logic [31:0] mem_addr, mem_d_in;
    logic [3:0]  mem_be;
    logic [31:0] mem_d_out = '0;
    logic        mem_out_valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;
    bit m_last   = 1'b0;   // model: owner of the last completed access, 0 = fetch, 1 = data

    storage_arbiter dut (
        .clk                (clk),
        .rst                (rst),
        .if_req_i           (if_req),
        .if_addr_i          (if_addr),
        .if_gnt_o           (if_gnt),
        .if_rvalid_o        (if_rvalid),
        .if_rdata_o         (if_rdata),
        .if_err_o           (if_err),
        .d_req_i            (d_req),
        .d_we_i             (d_we),
        .d_be_i             (d_be),
        .d_addr_i           (d_addr),
        .d_wdata_i          (d_wdata),
        .d_gnt_o            (d_gnt),
        .d_rvalid_o         (d_rvalid),
        .d_rdata_o          (d_rdata),
        .d_err_o            (d_err),
        .programming_mode_i (pmode),
        .mem_access_o       (mem_access),
        .mem_is_writing_o   (mem_is_writing),
        .mem_addr_o         (mem_addr),
        .mem_d_in_o         (mem_d_in),
        .mem_be_o           (mem_be),
        .mem_ext_o          (mem_ext),
        .mem_d_out_i        (mem_d_out),
        .mem_out_valid_i    (mem_out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 1'b0;
        d_req = 1'b0;
        d_we = 1'b0;
        pmode = 1'b0;
        mem_out_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_last = 1'b0;
    endtask

    // Full access from an IDLE cycle: grant check, k ISSUE cycles (valid on the k-th), RESP check.
    task automatic run_txn(input bit rq_if, input bit rq_d, input bit we, input logic [3:0] be,
                           input logic [31:0] a_if, input logic [31:0] a_d, input logic [31:0] wd,
                           input int k, input logic [31:0] rd);
        bit          own;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [3:0]  e_be;
        bit          e_we;
        own = (rq_if && rq_d) ? ~m_last : rq_d;
        e_addr = own ? a_d : a_if;
        e_we   = own & we;
        e_be   = own ? be : 4'hF;
        e_wd   = own ? wd : 32'h0;
        if_req = rq_if; if_addr = a_if;
        d_req = rq_d; d_we = we; d_be = be; d_addr = a_d; d_wdata = wd;
        #1;
        chk1("gnt_if", if_gnt, !own);
        chk1("gnt_d", d_gnt, own);
        step();
        if (own) d_req = 1'b0; else if_req = 1'b0;
        for (int j = 1; j <= k; j++) begin
            if (j == k) begin
                mem_out_valid = 1'b1;
                mem_d_out = rd;
            end
            #1;
            chk1("issue_access", mem_access, 1'b1);
            chk("issue_addr", mem_addr, e_addr);
            chk1("issue_we", mem_is_writing, e_we);
            chk("issue_be", 32'(mem_be), 32'(e_be));
            chk("issue_din", mem_d_in, e_wd);
            chk1("issue_ext", mem_ext, e_addr >= 32'h1000);
            chk1("issue_no_gnt", if_gnt | d_gnt, 1'b0);
            chk1("issue_no_rvalid", if_rvalid | d_rvalid, 1'b0);
            step();
            mem_out_valid = 1'b0;
            mem_d_out = $urandom;
        end
        #1;
        chk1("resp_rvalid_owner", own ? d_rvalid : if_rvalid, 1'b1);
        chk1("resp_rvalid_other", own ? if_rvalid : d_rvalid, 1'b0);
        chk("resp_rdata", own ? d_rdata : if_rdata, rd);
        chk1("resp_err", own ? d_err : if_err, 1'b0);
        chk1("resp_access_low", mem_access, 1'b0);
        chk1("resp_no_gnt", if_gnt | d_gnt, 1'b0);
        m_last = own;
        step();
        chk1("idle_rvalid_low", if_rvalid | d_rvalid, 1'b0);
        chk("idle_rdata_hold", own ? d_rdata : if_rdata, rd);
        n_txn++;
        $display("txn %0d: owner=%s addr=%h we=%0d k=%0d rdata=%h", n_txn, own ? "data" : "fetch",
                 e_addr, e_we, k, rd);
    endtask

    // Fetch to external space; valid either withheld or supplied exactly on the limit cycle.
    task automatic timeout_run(input bit valid_at_limit, input logic [31:0] rd);
        if_req = 1'b1; if_addr = 32'h0000_2000; d_req = 1'b0;
        #1;
        chk1("to_gnt", if_gnt, 1'b1);
        step();
        if_req = 1'b0;
        for (int c = 1; c <= 1024; c++) begin
            if (valid_at_limit && c == 1024) begin
                mem_out_valid = 1'b1;
                mem_d_out = rd;
            end
            #1;
            chk1("to_no_early_rvalid", if_rvalid, 1'b0);
            if (c == 1 || c == 1024) begin
                chk1("to_access", mem_access, 1'b1);
                chk1("to_ext", mem_ext, 1'b1);
            end
            step();
            mem_out_valid = 1'b0;
        end
        #1;
        chk1("to_rvalid", if_rvalid, 1'b1);
        chk1("to_err", if_err, !valid_at_limit);
        chk("to_rdata", if_rdata, valid_at_limit ? rd : 32'h0);
        chk1("to_d_rvalid", d_rvalid, 1'b0);
        m_last = 1'b0;
        step();
        n_txn++;
        $display("txn %0d: owner=fetch addr=00002000 timeout valid_at_limit=%0d", n_txn, valid_at_limit);
    endtask

    typedef struct {
        bit pre;
        bit pre_own;
        bit rq_if;
        bit rq_d;
        bit pm;
        bit e_if;
        bit e_d;
    } arb_vec_t;

    arb_vec_t tbl [9];

    initial begin
        tbl[0] = '{0, 0, 1, 0, 0, 1, 0};
        tbl[1] = '{0, 0, 0, 1, 0, 0, 1};
        tbl[2] = '{0, 0, 1, 1, 0, 0, 1};
        tbl[3] = '{1, 0, 1, 1, 0, 0, 1};
        tbl[4] = '{1, 1, 1, 1, 0, 1, 0};
        tbl[5] = '{1, 1, 0, 1, 0, 0, 1};
        tbl[6] = '{0, 0, 1, 1, 1, 0, 0};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 0};
        tbl[8] = '{1, 0, 1, 0, 0, 1, 0};

        // Reset state
        do_reset();
        chk1("rst_access", mem_access, 1'b0);
        chk1("rst_writing", mem_is_writing, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_din", mem_d_in, 32'h0);
        chk("rst_be", 32'(mem_be), 32'h0);
        chk1("rst_ext", mem_ext, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk1("rst_rvalid", if_rvalid | d_rvalid, 1'b0);
        chk1("rst_err", if_err | d_err, 1'b0);
        chk1("rst_gnt", if_gnt | d_gnt, 1'b0);

        // Arbitration table
        for (int i = 0; i < 9; i++) begin
            do_reset();
            if (tbl[i].pre)
                run_txn(!tbl[i].pre_own, tbl[i].pre_own, 1'b0, 4'hF, 32'h10, 32'h20, 32'h0, 1, 32'h1111_0000 + i);
            pmode = tbl[i].pm;
            if_req = tbl[i].rq_if;
            d_req = tbl[i].rq_d;
            #1;
            chk1($sformatf("tbl%0d_gnt_if", i), if_gnt, tbl[i].e_if);
            chk1($sformatf("tbl%0d_gnt_d", i), d_gnt, tbl[i].e_d);
        end

        // Data read from SRAM, valid one cycle into ISSUE
        do_reset();
        run_txn(1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0000_0040, 32'h0, 1, 32'hDEAD_BEEF);

        // Data write with partial byte enables, payload held across ISSUE
        run_txn(1'b0, 1'b1, 1'b1, 4'b0011, 32'h0, 32'h0000_0100, 32'h1234_5678, 3, 32'h0BAD_F00D);

        // Both ports requesting continuously: data, fetch, data, fetch
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 1'b1, 1'b0, 4'hF, 32'h200 + i * 4, 32'h400 + i * 4, 32'h0, 2, 32'hA000_0000 + i);
            chk1("alt_owner", m_last, (i % 2) == 0);
        end
        if_req = 1'b0; d_req = 1'b0;

        // Timeouts: valid withheld, then valid on the limit cycle
        do_reset();
        run_txn(1'b1, 1'b0, 1'b0, 4'hF, 32'h40, 32'h0, 32'h0, 1, 32'hA5A5_A5A5);
        timeout_run(1'b0, 32'h0);
        run_txn(1'b1, 1'b0, 1'b0, 4'hF, 32'h40, 32'h0, 32'h0, 1, 32'h5A5A_5A5A);
        timeout_run(1'b1, 32'h1357_9BDF);

        // Programming mode raised during an in-flight access
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        #1;
        chk1("pm_gnt_d", d_gnt, 1'b1);
        step();
        d_req = 1'b0; pmode = 1'b1; if_req = 1'b1; if_addr = 32'h44;
        for (int j = 1; j <= 5; j++) begin
            if (j == 5) begin
                mem_out_valid = 1'b1;
                mem_d_out = 32'hCAFE_F00D;
            end
            #1;
            chk1("pm_access", mem_access, 1'b1);
            chk1("pm_no_gnt_issue", if_gnt, 1'b0);
            step();
            mem_out_valid = 1'b0;
        end
        #1;
        chk1("pm_rvalid", d_rvalid, 1'b1);
        chk("pm_rdata", d_rdata, 32'hCAFE_F00D);
        chk1("pm_err", d_err, 1'b0);
        step();
        for (int j = 0; j < 3; j++) begin
            chk1("pm_blocked_gnt", if_gnt, 1'b0);
            chk1("pm_blocked_access", mem_access, 1'b0);
            step();
        end
        pmode = 1'b0;
        #1;
        chk1("pm_release_gnt", if_gnt, 1'b1);
        n_txn++;
        $display("txn %0d: owner=data addr=00000300 programming mode held over access", n_txn);

        // Reset pulsed mid-ISSUE
        do_reset();
        run_txn(1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h80, 32'h0, 1, 32'h55AA_55AA);
        if_req = 1'b1; if_addr = 32'h0000_2004;
        #1;
        chk1("rmid_gnt", if_gnt, 1'b1);
        step();
        if_req = 1'b0;
        #1;
        chk1("rmid_access_before", mem_access, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_last = 1'b0;
        chk1("rmid_access", mem_access, 1'b0);
        chk("rmid_addr", mem_addr, 32'h0);
        chk1("rmid_ext", mem_ext, 1'b0);
        chk("rmid_be", 32'(mem_be), 32'h0);
        chk("rmid_d_rdata", d_rdata, 32'h0);
        for (int j = 0; j < 3; j++) begin
            chk1("rmid_no_rvalid", if_rvalid | d_rvalid, 1'b0);
            step();
        end
        if_req = 1'b1; d_req = 1'b1;
        #1;
        chk1("rmid_tie_d", d_gnt, 1'b1);
        chk1("rmid_tie_if", if_gnt, 1'b0);
        n_txn++;
        $display("txn %0d: owner=fetch addr=00002004 aborted by reset", n_txn);

        // Randomized traffic against the round-robin model
        do_reset();
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(1, 3);
            run_txn(r[0], r[1], 1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom_range(0, 32'h1FFF)),
                    32'($urandom_range(0, 32'h1FFF)), $urandom, $urandom_range(1, 4), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
